// File: rtl/jt89_pan_mixer_if.sv
// Mixer bus: channel samples, pan control and stereo output grouped in one bundle.
// The master drives strobes and samples; the slave (mixer) returns the mix.
interface jt89_pan_mixer_if #(
  parameter int unsigned bw  = 9,
  parameter int unsigned nch = 4,
  parameter int unsigned ow  = 11
);
  logic                    cen;
  logic [nch*bw-1:0]       ch_l;
  logic [nch*bw-1:0]       ch_r;
  logic                    pan_we;
  logic [2*nch-1:0]        pan_din;
  logic                    mute;
  logic [2*nch-1:0]        pan;
  logic signed [ow-1:0]    sound_l;
  logic signed [ow-1:0]    sound_r;
  logic                    sample_valid;
  logic                    busy;
  logic                    overrun;

  modport master (
    output cen, ch_l, ch_r, pan_we, pan_din, mute,
    input  pan, sound_l, sound_r, sample_valid, busy, overrun
  );

  modport slave (
    input  cen, ch_l, ch_r, pan_we, pan_din, mute,
    output pan, sound_l, sound_r, sample_valid, busy, overrun
  );
endinterface

// File: rtl/jt89_pan_mixer.sv
// Serial stereo panning mixer: snapshot on cen, accumulate one channel per clock,
// saturate to ow bits. Pan writes are shadowed and committed at frame start.
module jt89_pan_mixer #(
  parameter int unsigned     bw      = 9,
  parameter int unsigned     nch     = 4,
  parameter int unsigned     ow      = 11,
  parameter logic [2*nch-1:0] PAN_RST = '1
) (
  input logic               clk,
  input logic               rst,
  jt89_pan_mixer_if.slave   bus
);
  localparam int unsigned aw = bw + $clog2(nch) + 1;
  localparam int unsigned iw = (nch > 1) ? $clog2(nch) : 1;
  localparam logic signed [aw-1:0] sat_hi = aw'((2 ** (ow - 1)) - 1);
  localparam logic signed [aw-1:0] sat_lo = aw'(-(2 ** (ow - 1)));

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  state_t                state_q, state_d;
  logic [iw-1:0]         idx_q, idx_d;
  logic signed [aw-1:0]  acc_l_q, acc_l_d, acc_r_q, acc_r_d;
  logic [nch*bw-1:0]     snap_l_q, snap_l_d, snap_r_q, snap_r_d;
  logic [2*nch-1:0]      pan_q, pan_d, shadow_q, shadow_d;
  logic                  pend_q, pend_d;
  logic signed [ow-1:0]  sound_l_q, sound_l_d, sound_r_q, sound_r_d;
  logic                  valid_q, valid_d, busy_q, busy_d, overrun_q, overrun_d;

  logic signed [bw-1:0]  snap_l_ch [nch];
  logic signed [bw-1:0]  snap_r_ch [nch];
  logic [nch-1:0]        pan_l, pan_r;
  logic signed [bw-1:0]  cur_l, cur_r;
  logic signed [aw-1:0]  ext_l, ext_r;

  for (genvar g = 0; g < int'(nch); g++) begin : g_unpack
    assign snap_l_ch[g] = snap_l_q[g*bw +: bw];
    assign snap_r_ch[g] = snap_r_q[g*bw +: bw];
  end

  assign pan_l = pan_q[2*nch-1:nch];
  assign pan_r = pan_q[nch-1:0];
  assign cur_l = snap_l_ch[idx_q];
  assign cur_r = snap_r_ch[idx_q];
  assign ext_l = {{(aw-bw){cur_l[bw-1]}}, cur_l};
  assign ext_r = {{(aw-bw){cur_r[bw-1]}}, cur_r};

  function automatic logic signed [ow-1:0] sat(input logic signed [aw-1:0] a);
    if (a > sat_hi)      sat = ow'(sat_hi);
    else if (a < sat_lo) sat = ow'(sat_lo);
    else                 sat = ow'(a);
  endfunction

  // Next-state and output computation
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    acc_l_d   = acc_l_q;
    acc_r_d   = acc_r_q;
    snap_l_d  = snap_l_q;
    snap_r_d  = snap_r_q;
    pan_d     = pan_q;
    shadow_d  = shadow_q;
    pend_d    = pend_q;
    sound_l_d = sound_l_q;
    sound_r_d = sound_r_q;
    valid_d   = 1'b0;
    busy_d    = busy_q;
    overrun_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.cen) begin
          snap_l_d = bus.ch_l;
          snap_r_d = bus.ch_r;
          if (pend_q) begin
            pan_d  = shadow_q;
            pend_d = 1'b0;
          end
          acc_l_d = '0;
          acc_r_d = '0;
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = ACC;
        end
      end
      ACC: begin
        overrun_d = bus.cen;
        acc_l_d   = acc_l_q + (pan_l[idx_q] ? ext_l : '0);
        acc_r_d   = acc_r_q + (pan_r[idx_q] ? ext_r : '0);
        idx_d     = idx_q + 1'b1;
        if (idx_q == iw'(nch - 1)) state_d = DONE;
      end
      DONE: begin
        overrun_d = bus.cen;
        sound_l_d = bus.mute ? '0 : sat(acc_l_q);
        sound_r_d = bus.mute ? '0 : sat(acc_r_q);
        valid_d   = 1'b1;
        busy_d    = 1'b0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A write on the committing edge lands after the commit, so it stays pending
    if (bus.pan_we) begin
      shadow_d = bus.pan_din;
      pend_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      acc_l_q   <= '0;
      acc_r_q   <= '0;
      snap_l_q  <= '0;
      snap_r_q  <= '0;
      pan_q     <= PAN_RST;
      shadow_q  <= '0;
      pend_q    <= 1'b0;
      sound_l_q <= '0;
      sound_r_q <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      acc_l_q   <= acc_l_d;
      acc_r_q   <= acc_r_d;
      snap_l_q  <= snap_l_d;
      snap_r_q  <= snap_r_d;
      pan_q     <= pan_d;
      shadow_q  <= shadow_d;
      pend_q    <= pend_d;
      sound_l_q <= sound_l_d;
      sound_r_q <= sound_r_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
    end
  end

  assign bus.pan          = pan_q;
  assign bus.sound_l      = sound_l_q;
  assign bus.sound_r      = sound_r_q;
  assign bus.sample_valid = valid_q;
  assign bus.busy         = busy_q;
  assign bus.overrun      = overrun_q;
endmodule

// File: doc/jt89_pan_mixer.md
Name: jt89_pan_mixer

Overview:
Generalised stereo panning mixer for SN76489/Game Gear-style PSGs with a parametrised channel count. It snapshots all channel outputs on a sample strobe and accumulates them serially, one channel per clock, into left/right accumulators gated by a pan register. It then saturates the sums to the output width and presents registered stereo samples with a valid pulse. Pan writes are double-buffered and applied only at sample-frame boundaries, so a mix never uses a half-updated pan setting. Sits between the tone/noise channel generators and the interpolator/DAC stage.

Parameters:
bw, 9, signed width of each channel sample
nch, 4, number of channels (1..16); channel nch-1 is conventionally noise
ow, 11, signed output width; must satisfy bw <= ow <= bw+clog2(nch)+1
PAN_RST, all ones (2*nch bits), pan value loaded at reset (GG power-on 0xFF)

Ports:
clk  in  1  system clock
rst  in  1  reset; synchronous, active-high
cen  in  1  sample strobe; starts one mix frame
ch_l  in  nch*bw  packed signed left inputs; channel k at [k*bw +: bw]
ch_r  in  nch*bw  packed signed right inputs, same packing
pan_we  in  1  pan write strobe
pan_din  in  2*nch  [nch-1:0] right enables, [2*nch-1:nch] left enables (GG byte layout when nch=4)
mute  in  1  forces output samples to zero; sampled at frame end
pan  out  2*nch  currently active pan value
sound_l  out  ow  signed left sample, registered
sound_r  out  ow  signed right sample, registered
sample_valid  out  1  one-cycle pulse when sound_l/sound_r update
busy  out  1  high while a frame is in progress
overrun  out  1  one-cycle pulse when cen is ignored because busy

Behaviour:
- Reset (sync, rst high at a clk edge): pan=PAN_RST; the shadow pan and its pending flag are cleared; sound_l=sound_r=0; sample_valid=0; busy=0; overrun=0; FSM=IDLE; accumulators=0. Reset mid-frame aborts the frame, and no sample_valid is produced.
- FSM states: IDLE, ACC, DONE.
  - IDLE and cen=1 at edge T:
    - Snapshot ch_l/ch_r into internal registers.
    - If a pan write is pending, commit the shadow to pan at the same edge and clear pending.
    - Clear both accumulators, set the channel index to 0, go to ACC, busy=1.
  - ACC, index k (edges T+1 .. T+nch):
    - acc_l += pan[nch+k] ? sext(snap_l[k]) : 0.
    - acc_r += pan[k] ? sext(snap_r[k]) : 0.
    - Increment k. After k=nch-1 is added, go to DONE.
  - DONE (edge T+nch+1):
    - sound_l/sound_r <= mute ? 0 : sat(acc).
    - sample_valid=1 for this cycle only; busy=0; go to IDLE.
  - Latency: cen at edge T produces sample_valid high in the cycle after edge T+nch+1. Frame length is nch+2 edges, so the maximum cen rate is one every nch+2 clocks.
- Accumulators are signed, width aw = bw+clog2(nch)+1; overflow inside the accumulator is impossible.
- Saturation:
  - If acc > 2^(ow-1)-1, output 2^(ow-1)-1.
  - If acc < -2^(ow-1), output -2^(ow-1).
  - Otherwise output acc truncated to ow bits, with no rounding.
- Pan writes:
  - pan_we stores pan_din into the shadow and sets pending.
  - Multiple writes before a commit keep the last one.
  - A pan_we on the same edge as the committing cen is not committed by that cen; it stays pending for the next frame.
  - The pan output reflects only committed values.
- cen while busy (in ACC or DONE): ignored; overrun pulses for one cycle; the frame in progress is unaffected.
- cen in IDLE on the cycle after DONE is accepted normally (back-to-back frames).
- Inputs are read only at the snapshot edge; changes during ACC do not affect the current frame.
- Outputs hold between sample_valid pulses.

Test Plan:
- Reset, no writes, nch=4, bw=9, ow=11; all ch_l=ch_r=100; pulse cen -> sample_valid high in the cycle after edge T+5; sound_l=sound_r=400; pan=8'hFF.
- pan_din=8'hA5 written, then cen; ch_l=ch_r={10,20,30,40} for ch0..3 -> left enables ch1,ch3: sound_l=60; right enables ch0,ch2: sound_r=40; pan=8'hA5 only after the cen edge.
- All four channels=+255 on both sides -> 1020 ≤ 1023, so sound_l=1020 with no clip. With ow=10 all +255 -> clips to 511; all -256 -> clips to -512.
- pan_we on the same edge as cen, then a second cen -> first frame uses the old pan, second frame uses the new pan.
- cen re-asserted 2 cycles after a frame starts -> overrun pulse for 1 cycle; single sample_valid; values are from the first snapshot. Change ch inputs mid-frame -> no effect on the result.
- rst asserted at edge T+2 of a frame -> no sample_valid; sound_l/r=0; busy=0; pan=PAN_RST. mute=1 with a non-zero mix -> sample_valid pulses with sound_l=sound_r=0.
